// File: rtl/multicycle_ctrl_fsm.sv
// Main sequencing controller for the multicycle 32-bit CPU.
// Steps each instruction through its states and drives datapath selects.
module multicycle_ctrl_fsm #(
    parameter logic [3:0] PC_REG = 4'd15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    input  logic       CondEx,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic       NextPC,
    output logic       RegW,
    output logic       MemW,
    output logic       PCS,
    output logic [1:0] ALUControl,
    output logic [1:0] FlagW,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXECR  = 4'd6,
        EXECI  = 4'd7,
        ALUWB  = 4'd8,
        BRANCH = 4'd9
    } state_t;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;
    localparam logic [3:0] CMD_CMP = 4'b1010;

    state_t state_q;
    state_t state_d;

    logic [3:0] cmd;
    logic       s_bit;
    logic       cmd_ok;
    logic [1:0] alu_dec;
    logic [1:0] flag_dec;
    logic       wb_ok;

    assign cmd   = Funct[4:1];
    assign s_bit = Funct[0];
    assign State = state_q;

    always_ff @(posedge clk) begin
        if (reset) state_q <= FETCH;
        else       state_q <= state_d;
    end

    // Unknown commands behave as a flagless ADD whose result is discarded.
    always_comb begin
        cmd_ok  = 1'b1;
        alu_dec = ALU_ADD;
        case (cmd)
            4'b0100:         alu_dec = ALU_ADD;
            4'b0010,
            4'b1010:         alu_dec = ALU_SUB;
            4'b0000:         alu_dec = ALU_AND;
            4'b1100:         alu_dec = ALU_ORR;
            default:         cmd_ok  = 1'b0;
        endcase
        flag_dec = 2'b00;
        if (cmd_ok) begin
            flag_dec[1] = s_bit;
            flag_dec[0] = s_bit & ((alu_dec == ALU_ADD) | (alu_dec == ALU_SUB));
        end
        if (cmd == CMD_CMP) flag_dec = 2'b11;
        wb_ok = cmd_ok & (cmd != CMD_CMP);
    end

    always_comb begin
        state_d    = FETCH;
        IRWrite    = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ResultSrc  = 2'b00;
        NextPC     = 1'b0;
        RegW       = 1'b0;
        MemW       = 1'b0;
        PCS        = 1'b0;
        ALUControl = ALU_ADD;
        FlagW      = 2'b00;
        case (state_q)
            FETCH: begin
                IRWrite   = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                NextPC    = 1'b1;
                state_d   = DECODE;
            end
            DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                if (CondEx) begin
                    case (Op)
                        2'b01:   state_d = MEMADR;
                        2'b10:   state_d = BRANCH;
                        2'b00:   state_d = Funct[5] ? EXECI : EXECR;
                        default: state_d = FETCH;
                    endcase
                end
            end
            MEMADR: begin
                ALUSrcB = 2'b01;
                state_d = Funct[0] ? MEMRD : MEMWR;
            end
            MEMRD: begin
                AdrSrc  = 1'b1;
                state_d = MEMWB;
            end
            MEMWB: begin
                ResultSrc = 2'b01;
                RegW      = 1'b1;
                PCS       = (Rd == PC_REG);
            end
            MEMWR: begin
                AdrSrc = 1'b1;
                MemW   = 1'b1;
            end
            EXECR, EXECI: begin
                ALUSrcB    = (state_q == EXECI) ? 2'b01 : 2'b00;
                ALUControl = alu_dec;
                FlagW      = flag_dec;
                state_d    = ALUWB;
            end
            ALUWB: begin
                RegW = wb_ok;
                PCS  = wb_ok & (Rd == PC_REG);
            end
            BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                PCS       = 1'b1;
            end
            default: state_d = FETCH;
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Scoreboard bench for multicycle_ctrl_fsm: predicted per-cycle output
// vectors are queued at issue and compared as the DUT steps.
module tb_multicycle_ctrl_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic       CondEx;
    logic       IRWrite, AdrSrc, ALUSrcA, NextPC, RegW, MemW, PCS;
    logic [1:0] ALUSrcB, ResultSrc, ALUControl, FlagW;
    logic [3:0] State;

    int checks = 0;
    int errors = 0;
    logic [18:0] sb[$];

    multicycle_ctrl_fsm dut (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd),
        .CondEx(CondEx), .IRWrite(IRWrite), .AdrSrc(AdrSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
        .NextPC(NextPC), .RegW(RegW), .MemW(MemW), .PCS(PCS),
        .ALUControl(ALUControl), .FlagW(FlagW), .State(State)
    );

    always #5 clk = ~clk;

    function automatic logic [18:0] act_vec();
        return {State, IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
                NextPC, RegW, MemW, PCS, ALUControl, FlagW};
    endfunction

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [18:0] model_out(input int ms, input logic [5:0] f,
                                              input logic [3:0] rd);
        logic [3:0] c;
        logic s, known, irw, adr, srca, npc, regw, memw, pcs;
        logic [1:0] srcb, rsrc, alu, flw;
        c = f[4:1];
        s = f[0];
        known = (c == 4'd4) || (c == 4'd2) || (c == 4'd10) ||
                (c == 4'd0) || (c == 4'd12);
        irw  = (ms == 0);
        npc  = (ms == 0);
        adr  = (ms == 3) || (ms == 5);
        srca = (ms <= 1);
        srcb = (ms <= 1) ? 2'd2 :
               (ms == 2 || ms == 7 || ms == 9) ? 2'd1 : 2'd0;
        rsrc = (ms <= 1 || ms == 9) ? 2'd2 : (ms == 4) ? 2'd1 : 2'd0;
        regw = (ms == 4) || (ms == 8 && known && c != 4'd10);
        memw = (ms == 5);
        pcs  = (ms == 9) || ((ms == 4 || ms == 8) && regw && rd == 4'd15);
        alu  = 2'd0;
        flw  = 2'd0;
        if (ms == 6 || ms == 7) begin
            if (c == 4'd2 || c == 4'd10) alu = 2'd1;
            else if (c == 4'd0)          alu = 2'd2;
            else if (c == 4'd12)         alu = 2'd3;
            if (c == 4'd10)  flw = 2'd3;
            else if (known)  flw = {s, s & (alu <= 2'd1)};
        end
        return {ms[3:0], irw, adr, srca, srcb, rsrc, npc, regw, memw, pcs,
                alu, flw};
    endfunction

    function automatic int model_next(input int ms, input logic [1:0] op,
                                      input logic [5:0] f, input logic cx);
        case (ms)
            0: return 1;
            1: begin
                if (!cx)        return 0;
                if (op == 2'd1) return 2;
                if (op == 2'd2) return 9;
                if (op == 2'd0) return f[5] ? 7 : 6;
                return 0;
            end
            2: return f[0] ? 3 : 5;
            3: return 4;
            6, 7: return 8;
            default: return 0;
        endcase
    endfunction

    // Called at a negedge with the DUT in FETCH.
    task automatic run_instr(input string tag, input logic [1:0] op,
                             input logic [5:0] f, input logic [3:0] rd,
                             input logic cx, input int lat);
        int ms;
        int n;
        int cyc;
        Op = op; Funct = f; Rd = rd; CondEx = cx;
        ms = 0;
        n = 0;
        do begin
            sb.push_back(model_out(ms, f, rd));
            ms = model_next(ms, op, f, cx);
            n++;
        end while (ms != 0 && n < 12);
        check({tag, "_lat"}, n, lat);
        cyc = 0;
        while (sb.size() > 0 && cyc < 12) begin
            check(tag, act_vec(), sb.pop_front());
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        check({tag, "_end"}, State, 4'd0);
    endtask

    initial begin
        reset = 1'b1; Op = 2'd0; Funct = 6'd0; Rd = 4'd0; CondEx = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_state", State, 4'd0);
        reset = 1'b0;

        run_instr("add",   2'd0, 6'b001000, 4'd1,  1'b1, 4);
        run_instr("subsi", 2'd0, 6'b100101, 4'd2,  1'b1, 4);
        run_instr("cmp",   2'd0, 6'b010101, 4'd0,  1'b1, 4);
        run_instr("ldr",   2'd1, 6'b000001, 4'd15, 1'b1, 5);
        run_instr("str",   2'd1, 6'b000000, 4'd3,  1'b1, 4);
        run_instr("b",     2'd2, 6'b000000, 4'd0,  1'b1, 3);
        run_instr("op11",  2'd3, 6'b001000, 4'd1,  1'b1, 2);
        run_instr("nc_ld", 2'd1, 6'b000001, 4'd15, 1'b0, 2);
        run_instr("nc_b",  2'd2, 6'b000000, 4'd0,  1'b0, 2);
        run_instr("addpc", 2'd0, 6'b001000, 4'd15, 1'b1, 4);
        run_instr("orr",   2'd0, 6'b011001, 4'd4,  1'b1, 4);
        run_instr("ands",  2'd0, 6'b100001, 4'd5,  1'b1, 4);
        run_instr("undef", 2'd0, 6'b000011, 4'd15, 1'b1, 4);

        for (int i = 0; i < 12; i++) begin
            logic [1:0] op;
            logic [5:0] f;
            logic       cx;
            int         lat;
            op  = 2'($urandom_range(0, 3));
            f   = 6'($urandom);
            cx  = 1'($urandom);
            lat = !cx ? 2 : (op == 2'd3) ? 2 : (op == 2'd2) ? 3 :
                  (op == 2'd0) ? 4 : (f[0] ? 5 : 4);
            run_instr("rnd", op, f, 4'($urandom), cx, lat);
        end

        // Abandon an ADD in EXECR with a two-cycle reset.
        Op = 2'd0; Funct = 6'b001000; Rd = 4'd1; CondEx = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("pre_rst", State, 4'd6);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("rel_state", State, 4'd0);
        check("rel_irw",   IRWrite, 1'b1);
        check("rel_npc",   NextPC, 1'b1);
        check("rel_srcb",  ALUSrcB, 2'b10);
        check("rel_wr",    {RegW, MemW, PCS}, 3'b000);
        run_instr("post", 2'd1, 6'b000000, 4'd2, 1'b1, 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl_fsm.md
Name: multicycle_ctrl_fsm

Overview:
Main sequencing controller for the multicycle 32-bit CPU. It steps each instruction through fetch/decode/execute/memory/writeback states and drives the datapath mux selects and enables. It also decodes the ALU command and flag-write enables. Raw write requests (RegW, MemW, PCS) and FlagW go to the condition logic block, which gates them with the evaluated condition and returns CondEx.

Parameters:
PC_REG, 4'd15, register index treated as the PC; writes to it assert PCS.

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high; forces state to FETCH
Op  input  2  Instr[27:26]: 00 data-proc, 01 memory, 10 branch
Funct  input  6  Instr[25:20]: [5]=I (immediate), [4:1]=cmd, [0]=S (set flags) / L (load)
Rd  input  4  Instr[15:12]
CondEx  input  1  condition-passed, from condition logic
IRWrite  output  1  instruction register load enable
AdrSrc  output  1  memory address select: 0=PC, 1=ALU result register
ALUSrcA  output  1  0=register A, 1=PC
ALUSrcB  output  2  00=register B, 01=ExtImm, 10=constant 4
ResultSrc  output  2  00=ALUOut, 01=read data, 10=ALU result direct
NextPC  output  1  unconditional PC update (fetch)
RegW  output  1  raw register-write request
MemW  output  1  raw memory-write request
PCS  output  1  raw PC-source request
ALUControl  output  2  00 ADD, 01 SUB, 10 AND, 11 ORR
FlagW  output  2  [1]=N/Z write, [0]=C/V write (raw)
State  output  4  current state encoding, for debug/verification

Behaviour:
- Moore outputs decoded from State. ALUControl and FlagW also depend on Funct. Registered state only; no output registers.
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9. Codes 10–15 are illegal and go to FETCH next cycle with all outputs 0.
- Reset (sync): State=FETCH at the next edge, regardless of current state. Mid-instruction reset abandons the instruction; no RegW or MemW is asserted in the reset cycle's successor.
- FETCH: IRWrite=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, NextPC=1. Next state is DECODE.
- DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
  - If CondEx=0, next state is FETCH (early skip).
  - Otherwise: Op=01 goes to MEMADR; Op=10 goes to BRANCH; Op=00 goes to EXECI if Funct[5]=1, else EXECR; Op=11 goes to FETCH.
- MEMADR: ALUSrcA=0, ALUSrcB=01, ALUControl=ADD. Next state is MEMRD if Funct[0]=1, else MEMWR.
- MEMRD: AdrSrc=1, ResultSrc=00. Next state is MEMWB.
- MEMWB: ResultSrc=01, RegW=1. Next state is FETCH.
- MEMWR: AdrSrc=1, MemW=1. Next state is FETCH.
- EXECR: ALUSrcA=0, ALUSrcB=00, ALU decode active. Next state is ALUWB.
- EXECI: ALUSrcA=0, ALUSrcB=01, ALU decode active. Next state is ALUWB.
- ALUWB: ResultSrc=00. RegW=1 unless cmd=1010 (CMP), in which case RegW=0. Next state is FETCH.
- BRANCH: ALUSrcA=0, ALUSrcB=01, ResultSrc=10, ALUControl=ADD, PCS=1. Next state is FETCH.
- PCS also asserts in MEMWB and ALUWB when Rd==PC_REG and RegW=1.
- ALU decode (EXECR/EXECI only) by cmd:
  - 0100 gives ADD; 0010 and 1010 give SUB; 0000 gives AND; 1100 gives ORR.
  - Any other cmd gives ADD with FlagW=00 and RegW suppressed in ALUWB.
  - FlagW[1]=S. FlagW[0]=S and (ADD or SUB).
  - CMP (1010) forces FlagW=11.
- Outside EXECR/EXECI: FlagW=00, and ALUControl=ADD.
- Unlisted outputs are 0 in every state.
- Latency per instruction: LDR 5 cycles, STR 4, data-proc 4, branch 3, condition-failed or undefined 2.

Test Plan:
- reset=1 for 2 cycles from EXECR -> State=0, IRWrite=1, NextPC=1, ALUSrcB=10 in the first cycle after release.
- ADD R1 (Op=00, Funct=001000, Rd=1, CondEx=1) -> states 0,1,6,8,0; ALUControl=00 and FlagW=00 in EXECR; RegW=1 and PCS=0 in ALUWB.
- SUBS immediate (Funct=100101) -> EXECI with ALUControl=01, FlagW=11.
- CMP (Funct=010101) -> EXECR with FlagW=11; ALUWB with RegW=0.
- LDR (Op=01, Funct=000001, Rd=15) -> 0,1,2,3,4,0; MEMWB RegW=1, PCS=1.
- STR (Funct=000000) -> MEMWR MemW=1, AdrSrc=1, then FETCH.
- B (Op=10) -> BRANCH PCS=1.
- Op=11 -> 0,1,0.
- Any instruction with CondEx=0 in DECODE -> back to FETCH; RegW, MemW and PCS never asserted.
